// File: rtl/tmr1_peripheral.sv
// Timer1 peripheral: 16-bit TMR1 counter with T1CON control, clocked from
// the system clock or a synchronised external pin through a 1/2/4/8
// prescaler, and a one-cycle overflow pulse for PIR1.TMR1IF.
// Optional feature macro: TMR1_WRITE_BUFFER_EN (buffered TMR1H writes,
// committed atomically by the following TMR1L write).
module tmr1_peripheral #(
  parameter logic [8:0] TMR1L_ADDR = 9'h00E,
  parameter logic [8:0] TMR1H_ADDR = 9'h00F,
  parameter logic [8:0] T1CON_ADDR = 9'h010
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] addr,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  input  logic       sel,
  output logic [7:0] data_out,
  input  logic       t1cki,
  output logic       tmr1if_set
);

  logic [15:0] tmr1_q,    tmr1_d;
  logic [5:0]  t1con_q,   t1con_d;
  logic [2:0]  presc_q,   presc_d;
  logic        sync1_q,   sync1_d;
  logic        sync2_q,   sync2_d;
  logic        edge_q,    edge_d;
  logic        tmr1if_q,  tmr1if_d;
`ifdef TMR1_WRITE_BUFFER_EN
  logic [7:0]  hbuf_q,    hbuf_d;
`endif

  logic       hit_l, hit_h, hit_con;
  logic       wr_l, wr_h, wr_con;
  logic       tmr_wr;
  logic       ext_edge;
  logic       count_evt;
  logic [2:0] presc_max;
  logic       tmr1_inc;

  // Address decode: all nine address bits must match, and only when routed to us.
  always_comb begin
    hit_l   = sel && (addr == TMR1L_ADDR);
    hit_h   = sel && (addr == TMR1H_ADDR);
    hit_con = sel && (addr == T1CON_ADDR);
    wr_l    = hit_l   && wr_en;
    wr_h    = hit_h   && wr_en;
    wr_con  = hit_con && wr_en;
    tmr_wr  = wr_l || wr_h;
  end

  // Combinational read mux; unclaimed addresses and T1CON[7:6] read as zero.
  always_comb begin
    // NOTE: a default assignment at the top of every always_comb keeps each
    // path assigned, so no latch can be inferred.
    data_out = 8'h00;
    if (hit_l)        data_out = tmr1_q[7:0];
    else if (hit_h)   data_out = tmr1_q[15:8];
    else if (hit_con) data_out = {2'b00, t1con_q};
  end

  // Count-event generation and prescaler terminal value.
  always_comb begin
    // Rising edge of the synchronised pin: new level high, previous level low.
    ext_edge  = sync2_q && !edge_q;
    count_evt = t1con_q[0] && (t1con_q[1] ? ext_edge : 1'b1);
    case (t1con_q[5:4])
      2'd0:    presc_max = 3'd0;
      2'd1:    presc_max = 3'd1;
      2'd2:    presc_max = 3'd3;
      default: presc_max = 3'd7;
    endcase
    // A timer-byte write on the same edge takes priority over the increment.
    tmr1_inc = count_evt && (presc_q == presc_max) && !tmr_wr;
  end

  // Next-state logic for timer, control, prescaler, synchroniser and pulse.
  always_comb begin
    tmr1_d   = tmr1_q;
    t1con_d  = t1con_q;
    presc_d  = presc_q;
    tmr1if_d = 1'b0;
`ifdef TMR1_WRITE_BUFFER_EN
    hbuf_d   = hbuf_q;
`endif

    // The synchroniser runs whether or not the timer is on.
    sync1_d = t1cki;
    sync2_d = sync1_q;
    edge_d  = sync2_q;

    if (wr_con) t1con_d = data_in[5:0];

    if (wr_l || wr_h || wr_con) begin
      presc_d = 3'd0;
    end else if (count_evt) begin
      presc_d = (presc_q == presc_max) ? 3'd0 : presc_q + 3'd1;
    end

    if (tmr1_inc) begin
      tmr1_d   = tmr1_q + 16'd1;
      tmr1if_d = (tmr1_q == 16'hFFFF);
    end

`ifdef TMR1_WRITE_BUFFER_EN
    // High byte is staged; the low-byte write commits both halves together.
    if (wr_h) hbuf_d = data_in;
    if (wr_l) tmr1_d = {hbuf_q, data_in};
`else
    // Each byte is written directly; the other byte holds its value.
    if (wr_l) tmr1_d[7:0]  = data_in;
    if (wr_h) tmr1_d[15:8] = data_in;
`endif
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all flops so every register samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      tmr1_q   <= 16'h0000;
      t1con_q  <= 6'h00;
      presc_q  <= 3'd0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      edge_q   <= 1'b0;
      tmr1if_q <= 1'b0;
`ifdef TMR1_WRITE_BUFFER_EN
      hbuf_q   <= 8'h00;
`endif
    end else begin
      tmr1_q   <= tmr1_d;
      t1con_q  <= t1con_d;
      presc_q  <= presc_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      edge_q   <= edge_d;
      tmr1if_q <= tmr1if_d;
`ifdef TMR1_WRITE_BUFFER_EN
      hbuf_q   <= hbuf_d;
`endif
    end
  end

  assign tmr1if_set = tmr1if_q;

endmodule

// File: tb/tb_tmr1_peripheral.sv
// Directed testbench for tmr1_peripheral with hand-computed expectations.
module tb_tmr1_peripheral;

  localparam logic [8:0] A_L   = 9'h00E;
  localparam logic [8:0] A_H   = 9'h00F;
  localparam logic [8:0] A_CON = 9'h010;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] addr;
  logic       wr_en;
  logic [7:0] data_in;
  logic       sel;
  logic [7:0] data_out;
  logic       t1cki;
  logic       tmr1if_set;

  int n_cmp = 0;
  int n_bad = 0;

  tmr1_peripheral dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wr_en      (wr_en),
    .data_in    (data_in),
    .sel        (sel),
    .data_out   (data_out),
    .t1cki      (t1cki),
    .tmr1if_set (tmr1if_set)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    sel     = 1'b1;
    wr_en   = 1'b1;
    addr    = a;
    data_in = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic [7:0] d);
    sel   = 1'b1;
    wr_en = 1'b0;
    addr  = a;
    #1;
    d = data_out;
  endtask

  task automatic rd16(output logic [15:0] v);
    logic [7:0] lo, hi;
    rd(A_L, lo);
    rd(A_H, hi);
    v = {hi, lo};
  endtask

  logic [7:0]  b;
  logic [15:0] v;

  initial begin
    rst = 1'b1; sel = 1'b0; wr_en = 1'b0; addr = '0; data_in = '0; t1cki = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    rd16(v);          check("reset_tmr1", v, 16'h0000);
    rd(A_CON, b);     check("reset_t1con", {8'h00, b}, 16'h0000);
    check("reset_if", {15'd0, tmr1if_set}, 16'h0000);

    // Clock source, 1:1: ten counts
    wr(A_CON, 8'h01);
    repeat (10) tick();
    rd(A_L, b);       check("count_1to1", {8'h00, b}, 16'h000A);

    // Turning off (edge still counts with old TMR1ON); upper bits read 0
    wr(A_CON, 8'hFC);
    rd(A_CON, b);     check("t1con_rdmask", {8'h00, b}, 16'h003C);
    repeat (3) tick();
    rd16(v);          check("frozen", v, 16'h000B);

    // 1:8 prescale, prescaler cleared by a TMR1L write
    wr(A_H, 8'h00);
    wr(A_L, 8'h00);
    wr(A_CON, 8'h31);
    repeat (7) tick();
    rd16(v);          check("ps8_before", v, 16'h0000);
    tick();
    rd16(v);          check("ps8_first", v, 16'h0001);
    repeat (3) tick();
    wr(A_L, 8'h55);
    repeat (7) tick();
    rd16(v);          check("ps8_clr_hold", v, 16'h0055);
    tick();
    rd16(v);          check("ps8_clr_inc", v, 16'h0056);

    // Overflow FFFE -> FFFF -> 0000 with a single-cycle pulse
    wr(A_CON, 8'h00);
    wr(A_H, 8'hFF);
    wr(A_L, 8'hFE);
    wr(A_CON, 8'h01);
    tick();
    rd16(v);          check("ovf_ffff", v, 16'hFFFF);
    check("ovf_if_pre", {15'd0, tmr1if_set}, 16'h0000);
    tick();
    rd16(v);          check("ovf_wrap", v, 16'h0000);
    check("ovf_if_hi", {15'd0, tmr1if_set}, 16'h0001);
    tick();
    check("ovf_if_lo", {15'd0, tmr1if_set}, 16'h0000);

    // External pin, 1:1: 3-cycle latency, then five pulses total
    wr(A_CON, 8'h00);
    wr(A_H, 8'h00);
    wr(A_L, 8'h00);
    wr(A_CON, 8'h03);
    t1cki = 1'b1;
    tick();
    tick();
    rd(A_L, b);       check("ext_lat2", {8'h00, b}, 16'h0000);
    tick();
    rd(A_L, b);       check("ext_lat3", {8'h00, b}, 16'h0001);
    tick();
    t1cki = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      t1cki = 1'b1;
      repeat (4) tick();
      t1cki = 1'b0;
      repeat (4) tick();
    end
    rd16(v);          check("ext_five", v, 16'h0005);

    // Write colliding with the overflowing increment
    wr(A_CON, 8'h00);
    wr(A_H, 8'hFF);
    wr(A_L, 8'hFF);
    wr(A_CON, 8'h01);
`ifdef TMR1_WRITE_BUFFER_EN
    wr(A_H, 8'h12);
    rd16(v);          check("buf_h_only", v, 16'hFFFF);
    check("buf_no_if", {15'd0, tmr1if_set}, 16'h0000);
    wr(A_L, 8'h34);
    rd16(v);          check("buf_commit", v, 16'h1234);
    check("buf_no_if2", {15'd0, tmr1if_set}, 16'h0000);
`else
    wr(A_H, 8'h12);
    rd16(v);          check("wr_wins", v, 16'h12FF);
    check("wr_no_if", {15'd0, tmr1if_set}, 16'h0000);
    tick();
    rd16(v);          check("wr_resume", v, 16'h1300);
    check("wr_no_if2", {15'd0, tmr1if_set}, 16'h0000);
`endif

    // sel low: no write, read returns zero
    wr(A_CON, 8'h00);
    wr(A_H, 8'h00);
    wr(A_L, 8'h10);
    sel = 1'b0; addr = A_L; wr_en = 1'b1; data_in = 8'hAA;
    #1;
    check("nosel_rd", {8'h00, data_out}, 16'h0000);
    tick();
    wr_en = 1'b0;
    rd16(v);          check("nosel_wr", v, 16'h0010);

    // Reset mid-count clears everything
    wr(A_CON, 8'h31);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd16(v);          check("rst_mid_tmr1", v, 16'h0000);
    rd(A_CON, b);     check("rst_mid_t1con", {8'h00, b}, 16'h0000);
    check("rst_mid_if", {15'd0, tmr1if_set}, 16'h0000);
    repeat (3) tick();
    rd16(v);          check("rst_mid_idle", v, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
